// File: rtl/b05_sample_store_if.sv
// b05_sample_store_if
// Bundles the producer handshake, the clear request and the scanner read port
// of the sample store.
//   master : producer/scanner side (drives WR_VALID, WR_DATA, CLEAR,
//            SCAN_BUSY, RD_ADDR; observes WR_READY, RD_DATA, COUNT, FULL, SAT)
//   slave  : the store itself (the opposite directions)
interface b05_sample_store_if;
    logic       WR_VALID;
    logic [9:0] WR_DATA;
    logic       WR_READY;
    logic       CLEAR;
    logic       SCAN_BUSY;
    logic [4:0] RD_ADDR;
    logic [8:0] RD_DATA;
    logic [5:0] COUNT;
    logic       FULL;
    logic       SAT;

    modport master (
        output WR_VALID, WR_DATA, CLEAR, SCAN_BUSY, RD_ADDR,
        input  WR_READY, RD_DATA, COUNT, FULL, SAT
    );

    modport slave (
        input  WR_VALID, WR_DATA, CLEAR, SCAN_BUSY, RD_ADDR,
        output WR_READY, RD_DATA, COUNT, FULL, SAT
    );
endinterface

// File: rtl/b05_sample_store.sv
// b05_sample_store
// 32-entry store of 9-bit saturated samples, filled by a valid/ready producer
// and read combinationally by a downstream peak scanner. While the scanner is
// busy the contents are frozen (LOCK); a clear requested during that time is
// deferred until the scanner releases the store.
// Ports:
//   CLOCK  : rising-edge clock for all state
//   RESET  : synchronous active-high reset
//   bus    : b05_sample_store_if.slave
//            WR_VALID/WR_DATA/WR_READY  producer handshake (10-bit signed sample)
//            CLEAR                      empty the store
//            SCAN_BUSY                  scanner reading, contents frozen
//            RD_ADDR/RD_DATA            combinational read port (50 if empty slot)
//            COUNT/FULL/SAT             occupancy, COUNT==32, sticky saturation
// Configuration:
//   B05_STORE_WRAP_EN  when defined, a full store keeps accepting samples by
//                      overwriting the oldest one, and reads are rotated so
//                      that address 0 is always the oldest sample.
module b05_sample_store (
    input  logic              CLOCK,
    input  logic              RESET,
    b05_sample_store_if.slave bus
);

`ifdef B05_STORE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [8:0] EMPTY_READ = 9'd50;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL_ST,
        LOCK
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [8:0]  mem [32];
    logic [31:0] valid_map;
    logic [4:0]  wp;
    logic [5:0]  count;
    logic        sat;
    logic        clear_pending;

    logic        wr_ready;
    logic        transfer;
    logic        do_clear;
    logic        is_full;
    logic [5:0]  count_after;
    logic        sample_hi;
    logic        sample_lo;
    logic [8:0]  sample_store;
    logic [4:0]  rd_index;

    assign is_full = (count == 6'd32);

    // A 10-bit two's complement value exceeds the 9-bit range exactly when
    // its top two bits differ: 01 means >255, 10 means < -256.
    assign sample_hi = !bus.WR_DATA[9] &&  bus.WR_DATA[8];
    assign sample_lo =  bus.WR_DATA[9] && !bus.WR_DATA[8];

    always_comb begin
        sample_store = bus.WR_DATA[8:0];
        if (sample_hi) begin
            sample_store = 9'd255;
        end else if (sample_lo) begin
            sample_store = 9'h100;
        end
    end

    // Next state and handshake. A busy scanner always forces LOCK; otherwise
    // a clear (fresh or deferred) empties the store, and the remaining states
    // simply follow the occupancy after this edge's transfer.
    always_comb begin
        wr_ready    = !bus.CLEAR && !bus.SCAN_BUSY && (state != LOCK) &&
                      ((state != FULL_ST) || WRAP_EN);
        transfer    = bus.WR_VALID && wr_ready;
        do_clear    = !bus.SCAN_BUSY && (bus.CLEAR || clear_pending);
        count_after = count;
        if (transfer && !is_full) begin
            count_after = count + 6'd1;
        end
        state_next  = state;
        if (bus.SCAN_BUSY) begin
            state_next = LOCK;
        end else if (do_clear) begin
            state_next = EMPTY;
        end else if (count_after == 6'd0) begin
            state_next = EMPTY;
        end else if (count_after == 6'd32) begin
            state_next = FULL_ST;
        end else begin
            state_next = FILL;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            valid_map     <= '0;
            wp            <= '0;
            count         <= '0;
            sat           <= 1'b0;
            clear_pending <= 1'b0;
        end else if (bus.SCAN_BUSY) begin
            // Contents frozen; remember the clear for when the scanner is done.
            if (bus.CLEAR) begin
                clear_pending <= 1'b1;
            end
        end else if (do_clear) begin
            valid_map     <= '0;
            wp            <= '0;
            count         <= '0;
            sat           <= 1'b0;
            clear_pending <= 1'b0;
        end else if (transfer) begin
            valid_map[wp] <= 1'b1;
            wp            <= wp + 5'd1;
            count         <= count_after;
            if (sample_hi || sample_lo) begin
                sat <= 1'b1;
            end
        end
    end

    // The sample array has no reset; stale entries are hidden by valid_map.
    always_ff @(posedge CLOCK) begin
        if (!RESET && transfer) begin
            mem[wp] <= sample_store;
        end
    end

    // Until the store first fills, WP equals COUNT and the oldest sample sits
    // at index 0, so rotation only applies once full (then WP is the oldest).
    assign rd_index = bus.RD_ADDR + ((WRAP_EN && is_full) ? wp : 5'd0);

    assign bus.RD_DATA  = valid_map[rd_index] ? mem[rd_index] : EMPTY_READ;
    assign bus.WR_READY = wr_ready;
    assign bus.COUNT    = count;
    assign bus.FULL     = is_full;
    assign bus.SAT      = sat;

endmodule
